// File: rtl/jk_pkg.sv
// Shared types for the JK command driver: op encoding, FSM states, op-to-drive decode.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } jk_state_e;

  // Returns {j, k} for an op.
  function automatic logic [1:0] jk_decode(input jk_op_e op);
    logic [1:0] jk;
    case (op)
      JK_HOLD:   jk = 2'b00;
      JK_RESET:  jk = 2'b01;
      JK_SET:    jk = 2'b10;
      JK_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for the JK driver; show-ahead read, extra pointer bit separates full from empty.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_wr;
  logic         w_rd;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr  = wr_en && !full;
  assign w_rd  = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/jk_cmd_driver.sv
// JK flop command sequencer: queues {op,count} commands and drives j/k for count cycles.
// Optional feedback checker compiled in with JK_CMD_CHECK_EN.
module jk_cmd_driver
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             exp_q,
  input  logic             q_fb,
  input  logic             nq_fb,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  jk_state_e        r_state, w_state_nxt;
  logic             r_j, r_k, w_j_nxt, w_k_nxt;
  logic [CNT_W-1:0] r_remain, w_remain_nxt;
  logic             r_exp_q;
  logic             w_pop, w_full, w_empty;
  logic [CNT_W+1:0] w_head;
  logic [1:0]       w_head_jk;
  logic [CNT_W-1:0] w_head_cnt;

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(CNT_W + 2)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cmd_valid),
    .wr_data ({cmd_op, cmd_count}),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_head_jk  = jk_decode(jk_op_e'(w_head[CNT_W+1:CNT_W]));
  assign w_head_cnt = (w_head[CNT_W-1:0] == '0) ? CNT_ONE : w_head[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_remain <= '0;
      r_exp_q  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_j      <= w_j_nxt;
      r_k      <= w_k_nxt;
      r_remain <= w_remain_nxt;
      // JK characteristic equation applied to the cycle just driven.
      if (r_state == ST_DRIVE) r_exp_q <= (r_j & ~r_exp_q) | (~r_k & r_exp_q);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_j_nxt      = r_j;
    w_k_nxt      = r_k;
    w_remain_nxt = r_remain;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_j_nxt = 1'b0;
        w_k_nxt = 1'b0;
        if (!w_empty) begin
          w_pop                = 1'b1;
          {w_j_nxt, w_k_nxt}   = w_head_jk;
          w_remain_nxt         = w_head_cnt;
          w_state_nxt          = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (r_remain == CNT_ONE) begin
          if (!w_empty) begin
            w_pop              = 1'b1;
            {w_j_nxt, w_k_nxt} = w_head_jk;
            w_remain_nxt       = w_head_cnt;
          end else begin
            w_j_nxt      = 1'b0;
            w_k_nxt      = 1'b0;
            w_remain_nxt = '0;
            w_state_nxt  = ST_IDLE;
          end
        end else begin
          w_remain_nxt = r_remain - CNT_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready = !w_full;
  assign busy      = (r_state == ST_DRIVE) || !w_empty;
  assign j         = r_j;
  assign k         = r_k;
  assign exp_q     = r_exp_q;

`ifdef JK_CMD_CHECK_EN
  logic r_chk_pend;
  logic r_err;

  // Feedback reflects a drive cycle one cycle after that cycle ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_pend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_chk_pend <= (r_state == ST_DRIVE);
      if (r_chk_pend && ((q_fb != r_exp_q) || (nq_fb == q_fb))) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_fb;
  assign w_unused_fb = q_fb ^ nq_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural JK flop closing the feedback loop.
module tb_jk_cmd_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_count = 4'd0;
  logic       j, k, busy, exp_q, err;
  logic       q_fb, nq_fb;
  logic       q_m;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

`ifdef JK_CMD_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  jk_cmd_driver #(.DEPTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .exp_q     (exp_q),
    .q_fb      (q_fb),
    .nq_fb     (nq_fb),
    .err       (err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_m <= 1'b0;
    else case ({j, k})
      2'b01:   q_m <= 1'b0;
      2'b10:   q_m <= 1'b1;
      2'b11:   q_m <= ~q_m;
      default: q_m <= q_m;
    endcase
  end

  assign q_fb  = force_en ? force_val : q_m;
  assign nq_fb = ~q_fb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++; if ({j, k} !== 2'b00) begin $display("FAIL reset_jk: got %b want 00", {j, k}); n_err++; end
    n_cmp++; if (cmd_ready !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", cmd_ready); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_err++; end
    n_cmp++; if (exp_q !== 1'b0) begin $display("FAIL reset_exp_q: got %b want 0", exp_q); n_err++; end
    n_cmp++; if (err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err); n_err++; end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_set();
    push(2'b10, 4'd3);
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL set_busy_at_push: got %b want 1", busy); n_err++; end
    n_cmp++; if ({j, k} !== 2'b00) begin $display("FAIL set_latency: got %b want 00", {j, k}); n_err++; end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({j, k} !== 2'b10) begin $display("FAIL set_drive[%0d]: got %b want 10", i, {j, k}); n_err++; end
    end
    tick();
    n_cmp++; if ({j, k} !== 2'b00) begin $display("FAIL set_end_jk: got %b want 00", {j, k}); n_err++; end
    n_cmp++; if (exp_q !== 1'b1) begin $display("FAIL set_exp_q: got %b want 1", exp_q); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL set_end_busy: got %b want 0", busy); n_err++; end
    n_cmp++; if (err !== 1'b0) begin $display("FAIL set_err: got %b want 0", err); n_err++; end
  endtask

  task automatic test_toggle();
    push(2'b01, 4'd2);
    repeat (3) tick();
    n_cmp++; if (exp_q !== 1'b0) begin $display("FAIL rst_exp_q: got %b want 0", exp_q); n_err++; end
    push(2'b11, 4'd0);
    tick();
    n_cmp++; if ({j, k} !== 2'b11) begin $display("FAIL tog_drive: got %b want 11", {j, k}); n_err++; end
    n_cmp++; if (exp_q !== 1'b0) begin $display("FAIL tog_exp_q_before: got %b want 0", exp_q); n_err++; end
    tick();
    n_cmp++; if ({j, k} !== 2'b00) begin $display("FAIL tog_one_cycle: got %b want 00", {j, k}); n_err++; end
    n_cmp++; if (exp_q !== 1'b1) begin $display("FAIL tog_exp_q_after: got %b want 1", exp_q); n_err++; end
    push(2'b11, 4'd0);
    repeat (2) tick();
    n_cmp++; if (exp_q !== 1'b0) begin $display("FAIL tog2_exp_q: got %b want 0", exp_q); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL tog2_busy: got %b want 0", busy); n_err++; end
  endtask

  task automatic test_back_to_back();
    logic [1:0] tbl [19];
    tbl = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
            2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    push(2'b00, 4'd15);
    push(2'b10, 4'd2);
    push(2'b01, 4'd1);
    push(2'b11, 4'd3);
    n_cmp++; if (cmd_ready !== 1'b1) begin $display("FAIL b2b_ready_3q: got %b want 1", cmd_ready); n_err++; end
    push(2'b01, 4'd1);
    n_cmp++; if (cmd_ready !== 1'b0) begin $display("FAIL b2b_ready_full: got %b want 0", cmd_ready); n_err++; end
    push(2'b10, 4'd2);
    for (int i = 0; i < 19; i++) begin
      tick();
      n_cmp++; if ({j, k} !== tbl[i]) begin $display("FAIL b2b_jk[%0d]: got %b want %b", i, {j, k}, tbl[i]); n_err++; end
      n_cmp++; if (busy !== (i < 17)) begin $display("FAIL b2b_busy[%0d]: got %b want %b", i, busy, (i < 17)); n_err++; end
      if (i == 16) begin
        n_cmp++; if (exp_q !== 1'b1) begin $display("FAIL b2b_exp_q_mid: got %b want 1", exp_q); n_err++; end
      end
    end
    n_cmp++; if (exp_q !== 1'b0) begin $display("FAIL b2b_exp_q_end: got %b want 0", exp_q); n_err++; end
  endtask

  task automatic test_reset_mid();
    push(2'b10, 4'd15);
    push(2'b11, 4'd1);
    push(2'b11, 4'd1);
    push(2'b11, 4'd1);
    n_cmp++; if ({j, k} !== 2'b10) begin $display("FAIL mid_pre_jk: got %b want 10", {j, k}); n_err++; end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({j, k} !== 2'b00) begin $display("FAIL mid_rst_jk: got %b want 00", {j, k}); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL mid_rst_busy: got %b want 0", busy); n_err++; end
    n_cmp++; if (cmd_ready !== 1'b1) begin $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); n_err++; end
    n_cmp++; if (exp_q !== 1'b0) begin $display("FAIL mid_rst_exp_q: got %b want 0", exp_q); n_err++; end
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_count = 4'd1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL mid_first_push: got %b want 1", busy); n_err++; end
    tick();
    n_cmp++; if ({j, k} !== 2'b10) begin $display("FAIL mid_post_jk: got %b want 10", {j, k}); n_err++; end
    tick();
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL mid_post_busy: got %b want 0", busy); n_err++; end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({j, k} !== 2'b00) begin $display("FAIL mid_flushed[%0d]: got %b want 00", i, {j, k}); n_err++; end
    end
    n_cmp++; if (exp_q !== 1'b1) begin $display("FAIL mid_exp_q: got %b want 1", exp_q); n_err++; end
  endtask

  task automatic test_checker();
    n_cmp++; if (err !== 1'b0) begin $display("FAIL chk_pre_err: got %b want 0", err); n_err++; end
    push(2'b01, 4'd1);
    repeat (3) tick();
    push(2'b10, 4'd1);
    tick();
    tick();
    force_en  = 1'b1;
    force_val = 1'b0;
    tick();
    force_en = 1'b0;
    n_cmp++; if (err !== EXP_ERR) begin $display("FAIL chk_err_set: got %b want %b", err, EXP_ERR); n_err++; end
    repeat (2) tick();
    push(2'b01, 4'd1);
    repeat (4) tick();
    n_cmp++; if (err !== EXP_ERR) begin $display("FAIL chk_err_sticky: got %b want %b", err, EXP_ERR); n_err++; end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0) begin $display("FAIL chk_err_clear: got %b want 0", err); n_err++; end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    test_checker();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
